sigmoid_backprop: RTL and testbench
===================================

Name: sigmoid_backprop

Overview:
- Backward-pass counterpart of the `sigmoid` activation block: computes the local gradient dx[i] = g[i] * y[i] * (1 - y[i]) for N packed IEEE-754 single-precision elements.
- `y` is the vector the forward `sigmoid` produced; `g` is the upstream gradient.
- Uses the same start/done handshake and packed-vector layout as `sigmoid`, so the training controller drives both blocks identically.
- One shared FP32 multiplier processes the elements serially.

Parameters:
- S, 32, element width in bits; only 32 (FP32) is supported.
- N, 2, number of elements per vector.

Ports:
- clk  input  1  clock, all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a new computation; sampled on a rising clk edge while rst_n is high.
- y  input  S*N  forward sigmoid outputs; element i occupies bits [S*i+S-1 : S*i].
- g  input  S*N  upstream gradients, same packing as `y`.
- dx  output  S*N  resulting gradients, same packing as `y`.
- done  output  1  high when `dx` holds a complete result.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, dx=0, done=0, element index=0, internal operand registers cleared. Takes effect immediately, including mid-operation; any partial result is discarded.
- Start acceptance: in IDLE or DONE, start=1 at a rising edge latches `y` and `g` into internal registers, clears done, sets index=0 and enters SUB. start is ignored in SUB, MUL_A and MUL_B. Inputs may change after the accepting edge.
- SUB (1 cycle): t = 1.0 - y[idx], computed exactly, then truncated to 24-bit significand.
  - Align the significand of y right by (127 - exp_y), subtract from 1.0, normalize by leading-zero count.
  - If y sign=1, or y is zero/denormal, or y >= 1.0 (exp_y >= 127): the element is saturated and dx[idx] = +0 (32'h00000000). The element still spends 3 cycles.
- MUL_A (1 cycle): p = y[idx] * t.
- MUL_B (1 cycle): r = p * g[idx]. At the clock edge that ends MUL_B, r is written into dx[idx]. If idx = N-1, go to DONE; otherwise idx+1 and go to SUB.
- DONE: done=1, held high until the next accepted start or reset. dx holds its value. Elements not yet rewritten during a run keep their previous values; dx is fully valid only while done=1.
- Latency: done rises 3*N cycles after the accepting edge (N=2: 6 cycles). Elements are processed lowest index first.
- FP multiply rules:
  - sign = XOR of the operand signs.
  - exp = ea + eb - 127, +1 if the product significand is >= 2.
  - Round toward zero (truncate).
  - Denormal operands are flushed to zero; any zero operand gives a signed zero.
  - Result exp < 1 gives signed zero (no denormals).
  - Result exp > 254 saturates to sign | 32'h7F7FFFFF.
- Back-to-back: start asserted in the DONE state is accepted the same cycle done falls.

Optional Feature:
- Macro: SIGMOID_BP_NAN_EN.
- Defined: an operand with exponent 255 is special.
  - NaN in y or g, or Inf in g with y saturated: dx[idx] = 32'h7FC00000.
  - Inf in g with valid y: sign | 32'h7F800000.
  - y = +Inf counts as saturated (>= 1.0), so +0 unless g is NaN/Inf as above.
- Not defined: exponent 255 is treated as an ordinary exponent using the normal multiply/saturate rules, with no NaN/Inf output. Example: g = 32'h7FC00000, y = 0.5 gives 32'h7EC00000.

Test Plan:
- y={32'h3F400000,32'h3F000000}, g={32'hC0000000,32'h3F800000}, pulse start -> done rises exactly 6 cycles later; dx={32'hBEC00000,32'h3E800000}.
- y={32'hBF000000,32'h3F800000}, g={32'h3F800000,32'h40A00000} (negative y, y=1.0) -> dx={32'h00000000,32'h00000000}, done after 6 cycles.
- y={32'h3F000000,32'h3F000000}, g={32'h00800000,32'h00000001} (min normal, denormal) -> both elements +0 (underflow, flush); result 32'h00000000.
- Run 1 above, then assert rst_n=0 two cycles after a second start -> dx=0 and done=0 immediately without a clock; after release, a fresh start produces correct results.
- done=1, re-pulse start with new vectors while done is high -> done drops at the accepting edge; new result after 6 cycles; start pulses during the run are ignored.
- y=32'h3F000000, g=32'h7FC00000 (NaN) -> 32'h7FC00000 with SIGMOID_BP_NAN_EN defined; 32'h7EC00000 without it.

Source files
------------

// File: rtl/sigmoid_backprop.sv
// Serial FP32 sigmoid backward pass: dx[i] = g[i] * y[i] * (1 - y[i]) over N packed elements.
// Optional macro SIGMOID_BP_NAN_EN turns on NaN/Inf handling for exponent-255 operands.
module sigmoid_backprop #(
    parameter int S = 32,
    parameter int N = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [S*N-1:0] y,
    input  logic [S*N-1:0] g,
    output logic [S*N-1:0] dx,
    output logic           done
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SUB   = 3'd1,
        MUL_A = 3'd2,
        MUL_B = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t         state_r, state_s;
    logic [S*N-1:0] y_r, g_r, dx_r;
    logic           done_r;
    logic [IW-1:0]  idx_r;
    logic [31:0]    t_r, p_r;
    logic           sat_r;
    logic [31:0]    y_el_s, g_el_s, t_s, p_s, r_s, res_s;
    logic           sat_s, accept_s;
`ifdef SIGMOID_BP_NAN_EN
    logic           y_nan_s, g_nan_s, g_inf_s;
`endif

    // Truncating FP32 multiply: denormals flush to zero, no denormal results, overflow clamps to max finite
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic              sign;
        logic [47:0]       prod;
        logic signed [9:0] e;
        logic [22:0]       m;
        sign = a[31] ^ b[31];
        prod = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e    = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
        if (prod[47]) begin
            e = e + 10'sd1;
            m = prod[46:24];
        end else begin
            m = prod[45:23];
        end
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) begin
            fmul = {sign, 31'd0};
        end else if (e < 10'sd1) begin
            fmul = {sign, 31'd0};
        end else if (e > 10'sd254) begin
            fmul = {sign, 31'h7F7FFFFF};
        end else begin
            fmul = {sign, e[7:0], m};
        end
    endfunction

    // 1.0 - a for 0 < a < 1; shifted-out bits of a fold into a sticky borrow so truncation stays exact
    function automatic logic [31:0] one_minus(input logic [30:0] a);
        logic [6:0]  sh;
        logic [53:0] ext;
        logic [26:0] yfx, diff, norm;
        logic        sticky;
        logic [4:0]  p;
        sh = 7'(8'd127 - a[30:23]);
        if (sh >= 7'd27) begin
            ext    = 54'd0;
            yfx    = 27'd0;
            sticky = 1'b1;
        end else begin
            ext    = {1'b1, a[22:0], 3'b000, 27'd0} >> sh;
            yfx    = ext[53:27];
            sticky = |ext[26:0];
        end
        diff = 27'h4000000 - yfx - {26'd0, sticky};
        p    = 5'd0;
        for (int i = 0; i < 26; i++) begin
            p = diff[i] ? 5'(i) : p;
        end
        norm      = diff << (5'd26 - p);
        one_minus = {1'b0, 8'd101 + {3'd0, p}, norm[25:3]};
    endfunction

    // Current-element operand selection and the arithmetic for each stage
    always_comb begin
        y_el_s = y_r[int'(idx_r)*S +: S];
        g_el_s = g_r[int'(idx_r)*S +: S];
        sat_s  = y_el_s[31] | (y_el_s[30:23] == 8'd0) | (y_el_s[30:23] >= 8'd127);
        t_s    = one_minus(y_el_s[30:0]);
        p_s    = fmul(y_el_s, t_r);
        r_s    = fmul(p_r, g_el_s);
`ifdef SIGMOID_BP_NAN_EN
        y_nan_s = (y_el_s[30:23] == 8'hFF) && (y_el_s[22:0] != 23'd0);
        g_nan_s = (g_el_s[30:23] == 8'hFF) && (g_el_s[22:0] != 23'd0);
        g_inf_s = (g_el_s[30:23] == 8'hFF) && (g_el_s[22:0] == 23'd0);
        if (y_nan_s || g_nan_s) begin
            res_s = 32'h7FC00000;
        end else if (g_inf_s) begin
            res_s = sat_r ? 32'h7FC00000 : {g_el_s[31] ^ y_el_s[31], 31'h7F800000};
        end else if (sat_r) begin
            res_s = 32'h00000000;
        end else begin
            res_s = r_s;
        end
`else
        res_s = sat_r ? 32'h00000000 : r_s;
`endif
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; start is only honoured in IDLE and DONE
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    state_s  = SUB;
                    accept_s = 1'b1;
                end else begin
                    state_s = state_r;
                end
            end
            SUB:     state_s = MUL_A;
            MUL_A:   state_s = MUL_B;
            MUL_B: begin
                if (idx_r == IW'(N - 1)) begin
                    state_s = DONE;
                end else begin
                    state_s = SUB;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Datapath: operand capture, stage pipeline registers and result write-back
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_r    <= '0;
            g_r    <= '0;
            dx_r   <= '0;
            done_r <= 1'b0;
            idx_r  <= '0;
            t_r    <= 32'd0;
            p_r    <= 32'd0;
            sat_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (accept_s) begin
                        y_r    <= y;
                        g_r    <= g;
                        idx_r  <= '0;
                        done_r <= 1'b0;
                    end
                end
                SUB: begin
                    t_r   <= t_s;
                    sat_r <= sat_s;
                end
                MUL_A: p_r <= p_s;
                MUL_B: begin
                    dx_r[int'(idx_r)*S +: S] <= res_s;
                    if (idx_r == IW'(N - 1)) begin
                        done_r <= 1'b1;
                    end else begin
                        idx_r <= idx_r + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign dx   = dx_r;
    assign done = done_r;
endmodule

// File: tb/tb_sigmoid_backprop.sv
// Table-driven scoreboard bench for sigmoid_backprop (N=2, FP32).
module tb_sigmoid_backprop;
    localparam int S = 32;
    localparam int N = 2;
    localparam int NV = 8;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [S*N-1:0] y     = '0;
    logic [S*N-1:0] g     = '0;
    logic [S*N-1:0] dx;
    logic           done;

    int tests = 0;
    int fails = 0;
    logic [S*N-1:0] sb_q[$];

    typedef struct {
        logic [63:0] y;
        logic [63:0] g;
        logic [63:0] dx;
    } vec_t;
    vec_t vecs[NV];

    sigmoid_backprop #(.S(S), .N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .y     (y),
        .g     (g),
        .dx    (dx),
        .done  (done)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic start_run(input logic [63:0] yv, input logic [63:0] gv, input logic [63:0] ev);
        @(negedge clk);
        y     = yv;
        g     = gv;
        start = 1'b1;
        sb_q.push_back(ev);
        @(posedge clk);
        #1;
        start = 1'b0;
        y     = ~yv;
        g     = ~gv;
    endtask

    task automatic wait_done(input string name, input bit inject);
        int cyc;
        logic [63:0] exp_v;
        cyc = 0;
        while (done !== 1'b1 && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
            if (inject && (cyc == 2 || cyc == 4)) begin
                start = 1'b1;
                y     = 64'h3F0000003F000000;
                g     = 64'h4000000040000000;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check({name, "_latency"}, 64'(cyc), 64'd6);
        if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s_scoreboard: got empty queue, expected a pending result", name);
        end else begin
            exp_v = sb_q.pop_front();
            check({name, "_dx"}, dx, exp_v);
        end
    endtask

    initial begin
        vecs[0] = '{64'h3F4000003F000000, 64'hC00000003F800000, 64'hBEC000003E800000};
        vecs[1] = '{64'hBF0000003F800000, 64'h3F80000040A00000, 64'h0000000000000000};
        vecs[2] = '{64'h3F0000003F000000, 64'h0080000000000001, 64'h0000000000000000};
        vecs[3] = '{64'h3E8000003F000000, 64'h3F80000040800000, 64'h3E4000003F800000};
        vecs[4] = '{64'h308000003F7FFFFF, 64'h3F8000003F800000, 64'h307FFFFF337FFFFF};
`ifdef SIGMOID_BP_NAN_EN
        vecs[5] = '{64'h3F0000003F000000, 64'h3F8000007FC00000, 64'h3E8000007FC00000};
`else
        vecs[5] = '{64'h3F0000003F000000, 64'h3F8000007FC00000, 64'h3E8000007EC00000};
`endif
        vecs[6] = '{64'h3FC0000000400000, 64'h3F8000003F800000, 64'h0000000000000000};
        vecs[7] = '{64'h3F0000003F400000, 64'hBF80000040000000, 64'hBE8000003EC00000};

        #2;
        check("reset_dx", dx, 64'd0);
        check("reset_done", 64'(done), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            start_run(vecs[i].y, vecs[i].g, vecs[i].dx);
            wait_done($sformatf("vec%0d", i), 1'b0);
        end

        // done and dx hold while idle in DONE
        repeat (3) @(posedge clk);
        #1;
        check("hold_done", 64'(done), 64'd1);
        check("hold_dx", dx, vecs[NV-1].dx);

        // back-to-back restart from DONE, with stray start pulses mid-run
        start_run(vecs[0].y, vecs[0].g, vecs[0].dx);
        check("b2b_done_fall", 64'(done), 64'd0);
        wait_done("b2b", 1'b1);

        // asynchronous reset two cycles into a run
        start_run(vecs[3].y, vecs[3].g, vecs[3].dx);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        check("midrst_dx", dx, 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        start_run(vecs[0].y, vecs[0].g, vecs[0].dx);
        wait_done("after_rst", 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
